// File: rtl/mips_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_core_pkg
//  Brief    : Shared types for the operand forwarding / scoreboard slice.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    typedef logic [4:0] MipsReg;

    localparam int NUM_REGS    = 32;
    localparam int LAT_WIDTH   = 3;
    localparam int OWNER_WIDTH = 32;

    // Owner is stored at full width; narrower instruction ids are zero-extended.
    typedef struct packed {
        logic                   busy;
        logic [LAT_WIDTH-1:0]   count;
        logic [OWNER_WIDTH-1:0] owner;
    } sb_entry_t;

    function automatic logic [LAT_WIDTH-1:0] lat_dec(input logic [LAT_WIDTH-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - LAT_WIDTH'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : forward_scoreboard_if
//  Brief    : Issue handshake and writer-retirement bundle for the scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
interface forward_scoreboard_if
    import mips_core_pkg::*;
#(
    parameter int ID_WIDTH = 20
);
    logic                issue_valid;
    logic                issue_ready;
    logic                issue_uses_rw;
    logic                issue_is_load;
    MipsReg              issue_rw_addr;
    logic [ID_WIDTH-1:0] issue_id;

    logic                wb_valid;
    MipsReg              wb_rw_addr;
    logic [ID_WIDTH-1:0] wb_id;

    modport master (
        output issue_valid, issue_uses_rw, issue_is_load, issue_rw_addr, issue_id,
        output wb_valid, wb_rw_addr, wb_id,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_uses_rw, issue_is_load, issue_rw_addr, issue_id,
        input  wb_valid, wb_rw_addr, wb_id,
        output issue_ready
    );
endinterface
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ============================================================================
//  Module   : forward_select
//  Brief    : Per-read-port bypass mux; youngest matching stage wins.
//  Revision : 1.0 - initial release
// ============================================================================
module forward_select
    import mips_core_pkg::*;
#(
    parameter int NUM_STAGES = 3
)(
    input  MipsReg                         i_rd_addr,
    input  logic [31:0]                    i_rf_data,
    input  logic [NUM_STAGES-1:0]          i_st_valid,
    input  logic [NUM_STAGES-1:0]          i_st_uses_rw,
    input  MipsReg [NUM_STAGES-1:0]        i_st_rw_addr,
    input  logic [NUM_STAGES-1:0][31:0]    i_st_data,
    output logic [31:0]                    o_fwd_data
);
    // Scan oldest to youngest so the lowest-index match overwrites last.
    always_comb begin
        o_fwd_data = i_rf_data;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (i_st_valid[s] && i_st_uses_rw[s] && (i_st_rw_addr[s] == i_rd_addr)) begin
                o_fwd_data = i_st_data[s];
            end
        end
        if (i_rd_addr == '0) begin
            o_fwd_data = '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : forward_scoreboard
//  Brief    : Register scoreboard with latency countdown, hazard/stall
//             generation and per-port operand forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module forward_scoreboard
    import mips_core_pkg::*;
#(
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 3,
    parameter int ALU_LAT    = 0,
    parameter int LOAD_LAT   = 1,
    parameter int ID_WIDTH   = 20
)(
    input  logic                          clk,
    input  logic                          rst,
    forward_scoreboard_if.slave           bus,
    input  logic [NUM_READ-1:0]           rd_uses,
    input  MipsReg [NUM_READ-1:0]         rd_addr,
    input  logic [NUM_READ-1:0][31:0]     rf_data,
    output logic [NUM_READ-1:0][31:0]     fwd_data,
    input  logic [NUM_STAGES-1:0]         st_valid,
    input  logic [NUM_STAGES-1:0]         st_uses_rw,
    input  MipsReg [NUM_STAGES-1:0]       st_rw_addr,
    input  logic [NUM_STAGES-1:0][31:0]   st_data,
    input  logic                          flush,
    output logic [NUM_READ-1:0]           hazard,
    output logic                          stall,
    output logic [31:0]                   stall_cycles
);
    localparam logic [LAT_WIDTH-1:0] c_alu_cnt  = LAT_WIDTH'(ALU_LAT);
    localparam logic [LAT_WIDTH-1:0] c_load_cnt = LAT_WIDTH'(LOAD_LAT);

    sb_entry_t              r_sb      [NUM_REGS];
    sb_entry_t              w_sb_next [NUM_REGS];
    logic [31:0]            r_stall_cycles;
    logic                   w_fire;
    logic                   w_issue_writes;
    logic [LAT_WIDTH-1:0]   w_issue_cnt;
    logic [OWNER_WIDTH-1:0] w_issue_owner;
    logic [OWNER_WIDTH-1:0] w_wb_owner;

    assign w_fire         = bus.issue_valid & bus.issue_ready & ~flush;
    assign w_issue_writes = w_fire & bus.issue_uses_rw & (bus.issue_rw_addr != '0);
    assign w_issue_cnt    = bus.issue_is_load ? c_load_cnt : c_alu_cnt;
    assign w_issue_owner  = OWNER_WIDTH'(bus.issue_id);
    assign w_wb_owner     = OWNER_WIDTH'(bus.wb_id);

    // Retirement is applied before issue so a same-cycle reissue keeps the entry.
    always_comb begin
        for (int e = 0; e < NUM_REGS; e++) begin
            w_sb_next[e] = r_sb[e];
            if (r_sb[e].busy) begin
                w_sb_next[e].count = lat_dec(r_sb[e].count);
            end
            if (bus.wb_valid && (bus.wb_rw_addr == MipsReg'(e)) &&
                (r_sb[e].owner == w_wb_owner)) begin
                w_sb_next[e].busy = 1'b0;
            end
            if (w_issue_writes && (bus.issue_rw_addr == MipsReg'(e))) begin
                w_sb_next[e].busy  = 1'b1;
                w_sb_next[e].count = w_issue_cnt;
                w_sb_next[e].owner = w_issue_owner;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_REGS; e++) begin
                r_sb[e] <= '0;
            end
            r_stall_cycles <= '0;
        end else begin
            for (int e = 0; e < NUM_REGS; e++) begin
                r_sb[e] <= w_sb_next[e];
            end
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            hazard[i] = rd_uses[i] && (rd_addr[i] != '0) &&
                        r_sb[rd_addr[i]].busy && (r_sb[rd_addr[i]].count != '0);
        end
    end

    assign stall           = |hazard;
    assign bus.issue_ready = ~stall;
    assign stall_cycles    = r_stall_cycles;

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_fwd
            forward_select #(
                .NUM_STAGES (NUM_STAGES)
            ) u_forward_select (
                .i_rd_addr    (rd_addr[p]),
                .i_rf_data    (rf_data[p]),
                .i_st_valid   (st_valid),
                .i_st_uses_rw (st_uses_rw),
                .i_st_rw_addr (st_rw_addr),
                .i_st_data    (st_data),
                .o_fwd_data   (fwd_data[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_forward_scoreboard
//  Brief    : Bench for forward_scoreboard; two instances (default latencies
//             and ALU_LAT=2/LOAD_LAT=5) share one stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_forward_scoreboard;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 issue_valid, issue_uses_rw, issue_is_load;
    logic [4:0]           issue_rw_addr;
    logic [19:0]          issue_id;
    logic                 wb_valid;
    logic [4:0]           wb_rw_addr;
    logic [19:0]          wb_id;
    logic                 flush;
    logic [1:0]           rd_uses;
    logic [1:0][4:0]      rd_addr;
    logic [1:0][31:0]     rf_data;
    logic [2:0]           st_valid, st_uses_rw;
    logic [2:0][4:0]      st_rw_addr;
    logic [2:0][31:0]     st_data;

    logic [1:0][31:0]     fwd_o   [2];
    logic [1:0]           haz_o   [2];
    logic                 stall_o [2];
    logic [31:0]          sc_o    [2];
    logic                 ready_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a busy register is unavailable until its ready cycle.
    int  cyc;
    bit  m_busy     [2][32];
    int  m_ready_at [2][32];
    int  m_owner    [2][32];
    longint m_sc    [2];

    forward_scoreboard_if #(.ID_WIDTH(20)) bus_a ();
    forward_scoreboard_if #(.ID_WIDTH(20)) bus_b ();

    assign bus_a.issue_valid   = issue_valid;
    assign bus_a.issue_uses_rw = issue_uses_rw;
    assign bus_a.issue_is_load = issue_is_load;
    assign bus_a.issue_rw_addr = issue_rw_addr;
    assign bus_a.issue_id      = issue_id;
    assign bus_a.wb_valid      = wb_valid;
    assign bus_a.wb_rw_addr    = wb_rw_addr;
    assign bus_a.wb_id         = wb_id;
    assign bus_b.issue_valid   = issue_valid;
    assign bus_b.issue_uses_rw = issue_uses_rw;
    assign bus_b.issue_is_load = issue_is_load;
    assign bus_b.issue_rw_addr = issue_rw_addr;
    assign bus_b.issue_id      = issue_id;
    assign bus_b.wb_valid      = wb_valid;
    assign bus_b.wb_rw_addr    = wb_rw_addr;
    assign bus_b.wb_id         = wb_id;
    assign ready_o[0]          = bus_a.issue_ready;
    assign ready_o[1]          = bus_b.issue_ready;

    forward_scoreboard dut_a (
        .clk (clk), .rst (rst), .bus (bus_a),
        .rd_uses (rd_uses), .rd_addr (rd_addr), .rf_data (rf_data), .fwd_data (fwd_o[0]),
        .st_valid (st_valid), .st_uses_rw (st_uses_rw), .st_rw_addr (st_rw_addr), .st_data (st_data),
        .flush (flush), .hazard (haz_o[0]), .stall (stall_o[0]), .stall_cycles (sc_o[0])
    );

    forward_scoreboard #(.ALU_LAT(2), .LOAD_LAT(5)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b),
        .rd_uses (rd_uses), .rd_addr (rd_addr), .rf_data (rf_data), .fwd_data (fwd_o[1]),
        .st_valid (st_valid), .st_uses_rw (st_uses_rw), .st_rw_addr (st_rw_addr), .st_data (st_data),
        .flush (flush), .hazard (haz_o[1]), .stall (stall_o[1]), .stall_cycles (sc_o[1])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic int m_lat(int d, bit is_load);
        if (d == 0) return is_load ? 1 : 0;
        return is_load ? 5 : 2;
    endfunction

    function automatic bit m_hazard(int d, int i);
        int a;
        a = int'(rd_addr[i]);
        return rd_uses[i] && (a != 0) && m_busy[d][a] && (cyc < m_ready_at[d][a]);
    endfunction

    function automatic bit m_stall(int d);
        return m_hazard(d, 0) || m_hazard(d, 1);
    endfunction

    function automatic logic [31:0] m_fwd(int i);
        if (rd_addr[i] == 5'd0) return 32'd0;
        for (int s = 0; s < 3; s++) begin
            if (st_valid[s] && st_uses_rw[s] && (st_rw_addr[s] == rd_addr[i])) return st_data[s];
        end
        return rf_data[i];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                m_busy[d][r] = 1'b0; m_ready_at[d][r] = 0; m_owner[d][r] = 0;
            end
            m_sc[d] = 0;
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rw = 0; issue_is_load = 0; issue_rw_addr = 0; issue_id = 0;
        wb_valid = 0; wb_rw_addr = 0; wb_id = 0; flush = 0;
        rd_uses = 0; rd_addr = '0; rf_data = '0;
        st_valid = 0; st_uses_rw = 0; st_rw_addr = '0; st_data = '0;
    endtask

    // Advance one clock edge and apply the architectural effect to the model.
    task automatic tick();
        bit fire [2];
        bit stl  [2];
        for (int d = 0; d < 2; d++) begin
            stl[d]  = m_stall(d);
            fire[d] = issue_valid && !stl[d] && !flush;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wb_valid && (m_owner[d][wb_rw_addr] == int'(wb_id))) m_busy[d][wb_rw_addr] = 1'b0;
                if (fire[d] && issue_uses_rw && (issue_rw_addr != 5'd0)) begin
                    m_busy[d][issue_rw_addr]     = 1'b1;
                    m_owner[d][issue_rw_addr]    = int'(issue_id);
                    m_ready_at[d][issue_rw_addr] = cyc + 1 + m_lat(d, issue_is_load);
                end
                if (stl[d] && (m_sc[d] != 64'hFFFF_FFFF)) m_sc[d]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rf_data[0] = 32'hA5A5_0001; rf_data[1] = 32'h5A5A_0002;
        rd_uses = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
        #1;
        n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall_o[0]); end
        n_cmp++; if (ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready_o[0]); end
        n_cmp++; if (haz_o[1] !== 2'b00) begin n_bad++; $display("FAIL reset_hazard_b: got %b expected 00", haz_o[1]); end
        n_cmp++; if (sc_o[0] !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cycles: got %0d expected 0", sc_o[0]); end
        n_cmp++; if (fwd_o[0][0] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL reset_fwd_rf: got %h expected a5a50001", fwd_o[0][0]); end
        n_cmp++; if (fwd_o[0][1] !== 32'd0) begin n_bad++; $display("FAIL reset_fwd_r0: got %h expected 0", fwd_o[0][1]); end
        tick(); tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_load_use();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 1; issue_rw_addr = 5'd5; issue_id = 20'd1;
        #1;
        n_cmp++; if (ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL load_issue_ready: got %b expected 1", ready_o[0]); end
        tick();
        idle();
        rd_uses[0] = 1'b1; rd_addr[0] = 5'd5; rf_data[0] = 32'h0000_1234;
        #1;
        n_cmp++; if (haz_o[0] !== 2'b01) begin n_bad++; $display("FAIL load_use_hazard: got %b expected 01", haz_o[0]); end
        n_cmp++; if (stall_o[0] !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got %b expected 1", stall_o[0]); end
        n_cmp++; if (ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL load_use_ready: got %b expected 0", ready_o[0]); end
        tick();
        st_valid[1] = 1'b1; st_uses_rw[1] = 1'b1; st_rw_addr[1] = 5'd5; st_data[1] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %b expected 0", stall_o[0]); end
        n_cmp++; if (fwd_o[0][0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_use_fwd: got %h expected deadbeef", fwd_o[0][0]); end
        n_cmp++; if (sc_o[0] !== 32'd1) begin n_bad++; $display("FAIL load_use_stall_cycles: got %0d expected 1", sc_o[0]); end
        n_cmp++; if (stall_o[1] !== 1'b1) begin n_bad++; $display("FAIL load_use_long_lat: got %b expected 1", stall_o[1]); end
        tick();
        idle();
    endtask

    task automatic test_priority();
        st_valid = 3'b101; st_uses_rw = 3'b101;
        st_rw_addr[0] = 5'd3; st_rw_addr[2] = 5'd3; st_data[0] = 32'h11; st_data[2] = 32'h33;
        rd_uses[1] = 1'b1; rd_addr[1] = 5'd3; rf_data[1] = 32'hFFFF_0003;
        #1;
        n_cmp++; if (fwd_o[0][1] !== 32'h11) begin n_bad++; $display("FAIL prio_youngest: got %h expected 11", fwd_o[0][1]); end
        n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL prio_no_stall: got %b expected 0", stall_o[0]); end
        st_uses_rw[0] = 1'b0;
        #1;
        n_cmp++; if (fwd_o[0][1] !== 32'h33) begin n_bad++; $display("FAIL prio_uses_rw_gate: got %h expected 33", fwd_o[0][1]); end
        st_uses_rw[0] = 1'b1; st_valid[0] = 1'b0;
        #1;
        n_cmp++; if (fwd_o[1][1] !== 32'h33) begin n_bad++; $display("FAIL prio_valid_gate: got %h expected 33", fwd_o[1][1]); end
        st_valid[2] = 1'b0;
        #1;
        n_cmp++; if (fwd_o[0][1] !== 32'hFFFF_0003) begin n_bad++; $display("FAIL prio_rf_fallback: got %h expected ffff0003", fwd_o[0][1]); end
        st_valid = 3'b111; st_uses_rw = 3'b111; st_rw_addr = '0; rd_addr[1] = 5'd0;
        #1;
        n_cmp++; if (fwd_o[0][1] !== 32'd0) begin n_bad++; $display("FAIL prio_r0_zero: got %h expected 0", fwd_o[0][1]); end
        tick();
        idle();
    endtask

    task automatic test_owner();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 1; issue_rw_addr = 5'd9; issue_id = 20'd7;
        tick();
        issue_id = 20'd8;
        tick();
        idle();
        wb_valid = 1; wb_rw_addr = 5'd9; wb_id = 20'd7;
        rd_uses[0] = 1'b1; rd_addr[0] = 5'd9;
        #1;
        n_cmp++; if (haz_o[1][0] !== 1'b1) begin n_bad++; $display("FAIL owner_busy: got %b expected 1", haz_o[1][0]); end
        tick();
        wb_valid = 0;
        #1;
        n_cmp++; if (haz_o[1][0] !== 1'b1) begin n_bad++; $display("FAIL owner_stale_wb: got %b expected 1", haz_o[1][0]); end
        wb_valid = 1; wb_id = 20'd8;
        tick();
        wb_valid = 0;
        #1;
        n_cmp++; if (haz_o[1][0] !== 1'b0) begin n_bad++; $display("FAIL owner_retire: got %b expected 0", haz_o[1][0]); end
        tick();
        idle();
    endtask

    task automatic test_same_cycle();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 1; issue_rw_addr = 5'd4; issue_id = 20'h21;
        tick();
        issue_id = 20'h22; wb_valid = 1; wb_rw_addr = 5'd4; wb_id = 20'h21;
        tick();
        idle();
        wb_valid = 1; wb_rw_addr = 5'd4; wb_id = 20'h21;
        rd_uses[1] = 1'b1; rd_addr[1] = 5'd4;
        #1;
        n_cmp++; if (haz_o[1][1] !== 1'b1) begin n_bad++; $display("FAIL same_cycle_issue_wins: got %b expected 1", haz_o[1][1]); end
        tick();
        #1;
        n_cmp++; if (haz_o[1][1] !== 1'b1) begin n_bad++; $display("FAIL same_cycle_new_owner: got %b expected 1", haz_o[1][1]); end
        wb_id = 20'h22;
        tick();
        wb_valid = 0;
        #1;
        n_cmp++; if (haz_o[1][1] !== 1'b0) begin n_bad++; $display("FAIL same_cycle_retire: got %b expected 0", haz_o[1][1]); end
        tick();
        idle();
    endtask

    task automatic test_reset_midcount();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 1; issue_rw_addr = 5'd6; issue_id = 20'h30;
        tick();
        idle();
        rd_uses[0] = 1'b1; rd_addr[0] = 5'd6; rf_data[0] = 32'hCAFE_0006;
        #1;
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_stall_a: got %b expected 0", stall_o[0]); end
        n_cmp++; if (stall_o[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_stall_b: got %b expected 0", stall_o[1]); end
        n_cmp++; if (sc_o[1] !== 32'd0) begin n_bad++; $display("FAIL midreset_stall_cycles: got %0d expected 0", sc_o[1]); end
        n_cmp++; if (fwd_o[0][0] !== 32'hCAFE_0006) begin n_bad++; $display("FAIL midreset_fwd: got %h expected cafe0006", fwd_o[0][0]); end
        tick();
        #1;
        n_cmp++; if (stall_o[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_after: got %b expected 0", stall_o[1]); end
        n_cmp++; if (sc_o[1] !== 32'd0) begin n_bad++; $display("FAIL midreset_sc_after: got %0d expected 0", sc_o[1]); end
        idle();
    endtask

    task automatic test_flush();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 1; issue_rw_addr = 5'd10; issue_id = 20'h41;
        tick();
        issue_rw_addr = 5'd2; issue_id = 20'h40; flush = 1;
        rd_uses[1] = 1'b1; rd_addr[1] = 5'd10;
        #1;
        n_cmp++; if (haz_o[1][1] !== 1'b1) begin n_bad++; $display("FAIL flush_keeps_older: got %b expected 1", haz_o[1][1]); end
        tick();
        idle();
        for (int k = 0; k < 6; k++) begin
            rd_uses[0] = 1'b1; rd_addr[0] = 5'd2;
            #1;
            n_cmp++; if (haz_o[1][0] !== 1'b0 || haz_o[0][0] !== 1'b0) begin
                n_bad++; $display("FAIL flush_suppress cycle %0d: got a=%b b=%b expected 0", k, haz_o[0][0], haz_o[1][0]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        issue_valid = 1; issue_uses_rw = 1; issue_is_load = 0; issue_rw_addr = 5'd7; issue_id = 20'h50;
        tick();
        idle();
        rd_uses[0] = 1'b1; rd_addr[0] = 5'd7;
        #1;
        n_cmp++; if (haz_o[0][0] !== 1'b0) begin n_bad++; $display("FAIL alu_zero_lat: got %b expected 0", haz_o[0][0]); end
        n_cmp++; if (haz_o[1][0] !== 1'b1) begin n_bad++; $display("FAIL alu_lat2_c1: got %b expected 1", haz_o[1][0]); end
        tick();
        n_cmp++; if (haz_o[1][0] !== 1'b1) begin n_bad++; $display("FAIL alu_lat2_c2: got %b expected 1", haz_o[1][0]); end
        tick();
        n_cmp++; if (haz_o[1][0] !== 1'b0) begin n_bad++; $display("FAIL alu_lat2_done: got %b expected 0", haz_o[1][0]); end
        idle();
        tick();
    endtask

    task automatic test_random();
        int a;
        for (int n = 0; n < 400; n++) begin
            issue_valid   = ($urandom_range(0, 1) == 1);
            issue_uses_rw = ($urandom_range(0, 4) != 0);
            issue_is_load = ($urandom_range(0, 1) == 1);
            issue_rw_addr = 5'($urandom_range(0, 7));
            issue_id      = 20'($urandom);
            flush         = ($urandom_range(0, 9) == 0);
            a             = $urandom_range(0, 7);
            wb_valid      = ($urandom_range(0, 2) == 0);
            wb_rw_addr    = 5'(a);
            wb_id         = ($urandom_range(0, 1) == 1) ? 20'(m_owner[$urandom_range(0, 1)][a]) : 20'($urandom);
            rd_uses       = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                rd_addr[i] = 5'($urandom_range(0, 7));
                rf_data[i] = $urandom;
            end
            st_valid   = 3'($urandom);
            st_uses_rw = 3'($urandom);
            for (int s = 0; s < 3; s++) begin
                st_rw_addr[s] = 5'($urandom_range(0, 7));
                st_data[s]    = $urandom;
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 2; i++) begin
                    n_cmp++; if (haz_o[d][i] !== m_hazard(d, i)) begin
                        n_bad++; $display("FAIL rnd_hazard dut%0d port%0d cyc %0d: got %b expected %b", d, i, cyc, haz_o[d][i], m_hazard(d, i));
                    end
                    n_cmp++; if (fwd_o[d][i] !== m_fwd(i)) begin
                        n_bad++; $display("FAIL rnd_fwd dut%0d port%0d cyc %0d: got %h expected %h", d, i, cyc, fwd_o[d][i], m_fwd(i));
                    end
                end
                n_cmp++; if (stall_o[d] !== m_stall(d) || ready_o[d] !== !m_stall(d)) begin
                    n_bad++; $display("FAIL rnd_stall dut%0d cyc %0d: got stall=%b ready=%b expected stall=%b", d, cyc, stall_o[d], ready_o[d], m_stall(d));
                end
                n_cmp++; if (sc_o[d] !== 32'(m_sc[d])) begin
                    n_bad++; $display("FAIL rnd_stall_cycles dut%0d cyc %0d: got %0d expected %0d", d, cyc, sc_o[d], m_sc[d]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        cyc = 0;
        test_reset();
        test_load_use();
        test_priority();
        test_owner();
        test_same_cycle();
        test_reset_midcount();
        test_flush();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter NUM_READ, default 2, number of operand read ports.
REQ-002 SHALL have parameter NUM_STAGES, default 3, forwarding sources; index 0 youngest (EX), NUM_STAGES-1 oldest (WB).
REQ-003 SHALL have parameter ALU_LAT, default 0, cycles until an ALU result is forwardable.
REQ-004 SHALL have parameter LOAD_LAT, default 1, cycles until a load result is forwardable; max(ALU_LAT, LOAD_LAT) <= 7.
REQ-005 SHALL have parameter ID_WIDTH, default 20, instruction id width.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: issue_valid in 1; issue_ready out 1; issue_uses_rw in 1; issue_is_load in 1; issue_rw_addr in 5; issue_id in ID_WIDTH.
REQ-008 SHALL have ports: rd_uses in NUM_READ; rd_addr in NUM_READ x 5; rf_data in NUM_READ x 32 (register file values); fwd_data out NUM_READ x 32.
REQ-009 SHALL have ports: st_valid in NUM_STAGES; st_uses_rw in NUM_STAGES; st_rw_addr in NUM_STAGES x 5; st_data in NUM_STAGES x 32.
REQ-010 SHALL have ports: wb_valid in 1; wb_rw_addr in 5; wb_id in ID_WIDTH (retirement of a writer).
REQ-011 SHALL have ports: flush in 1; hazard out NUM_READ; stall out 1; stall_cycles out 32.

Function
REQ-012 SHALL hold a 32-entry scoreboard; each entry: busy, count (3 bits), owner id.
REQ-013 SHALL accept an issue when issue_valid & issue_ready & ~flush (the "fire" condition).
REQ-014 On fire with issue_uses_rw and issue_rw_addr != 0, SHALL set entry busy=1, owner=issue_id, count=LOAD_LAT if issue_is_load else ALU_LAT, visible next cycle.
REQ-015 SHALL decrement every busy entry with count != 0 by 1 per cycle; count saturates at 0.
REQ-016 On wb_valid with wb_id == owner of entry wb_rw_addr, SHALL clear busy; a mismatching id leaves the entry unchanged.
REQ-017 Fire and wb on the same register in one cycle: issue SHALL win (entry reloaded with new owner).
REQ-018 hazard[i] SHALL be rd_uses[i] & rd_addr[i] != 0 & busy & count != 0, from registered state (combinational, same cycle).
REQ-019 stall SHALL be OR of hazard; issue_ready SHALL be ~stall.
REQ-020 fwd_data[i] SHALL be the st_data of the lowest-index stage with st_valid & st_uses_rw & st_rw_addr == rd_addr[i], else rf_data[i]; combinational, zero latency.
REQ-021 rd_addr == 0 SHALL always yield fwd_data 0 and no hazard.
REQ-022 flush SHALL suppress fire for that cycle only; existing entries (older producers) SHALL be untouched.
REQ-023 stall_cycles SHALL increment each cycle stall is 1 and saturate at 0xFFFF_FFFF.

Reset
REQ-024 On rst, SHALL asynchronously clear all busy, count, owner to 0 and stall_cycles to 0; hazard/stall are then 0 and issue_ready is 1.
REQ-025 Reset asserted mid-countdown SHALL discard all pending state; no stall after release until a new load fires.

Structure
REQ-026 Scoreboard entry struct and latency width constant SHALL live in mips_core_pkg; register addresses use mips_core_pkg::MipsReg.
REQ-027 The per-port priority mux SHALL be one sub-module, forward_select, instantiated NUM_READ times.

Verification
REQ-028 Load to r5 fires (LOAD_LAT=1), next cycle read port 0 reads r5 -> hazard[0]=1, stall=1 for exactly 1 cycle, then fwd_data[0]=st_data[1] (MEM value 0xDEAD_BEEF).
REQ-029 r3 valid in both stage 0 (0x11) and stage 2 (0x33), port 1 reads r3 -> fwd_data[1]=0x11, no stall.
REQ-030 Issue id 7 to r9, then id 8 to r9, wb id 7 on r9 -> entry stays busy with owner 8.
REQ-031 Fire to r4 and wb of r4's owner in same cycle -> busy=1, owner=new id.
REQ-032 Load to r6 fires, rst pulsed next cycle -> stall=0, stall_cycles=0, rf_data passed through.
REQ-033 issue_valid with flush=1 to r2 -> r2 never busy; reads of r2 never stall.
